// File: rtl/wb_port.sv
// Register-file write-port driver: merges ALU and buffered long-latency writebacks.
// Optional pending-destination scoreboard is built only when WB_SCOREBOARD_EN is defined.
module wb_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             ll_valid,
  output logic             ll_ready,
  input  logic [4:0]       ll_rd,
  input  logic [WIDTH-1:0] ll_data,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic             we3,
  output logic [4:0]       a3,
  output logic [WIDTH-1:0] wd3,
  output logic [31:0]      pend_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [4:0]       rd_mem_r   [DEPTH];
  logic [WIDTH-1:0] data_mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [4:0]       head_rd_s;
  logic [WIDTH-1:0] head_data_s;
  logic             sel_valid_s;
  logic [4:0]       sel_rd_s;
  logic [WIDTH-1:0] sel_data_s;

  assign empty_s     = (count_r == CNT_ZERO);
  assign full_s      = (count_r == FULL_CNT);
  assign ll_ready    = !full_s && !reset;
  assign push_s      = ll_valid && ll_ready;
  // The FIFO only drains in cycles the ALU leaves the port free.
  assign pop_s       = !alu_valid && !empty_s;
  assign head_rd_s   = rd_mem_r[rptr_r];
  assign head_data_s = data_mem_r[rptr_r];

  // Fixed-priority source select: ALU, then FIFO head, else idle.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_rd_s    = 5'd0;
    sel_data_s  = {WIDTH{1'b0}};
    if (alu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_rd;
      sel_data_s  = alu_data;
    end else if (pop_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = head_rd_s;
      sel_data_s  = head_data_s;
    end else begin
      sel_valid_s = 1'b0;
      sel_rd_s    = 5'd0;
      sel_data_s  = {WIDTH{1'b0}};
    end
  end

  // Registered write port; writes to x0 are suppressed here.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      a3  <= 5'd0;
      wd3 <= {WIDTH{1'b0}};
    end else begin
      we3 <= sel_valid_s && (sel_rd_s != 5'd0);
      a3  <= sel_rd_s;
      wd3 <= sel_data_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r  <= PTR_ZERO;
      rptr_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) wptr_r <= wptr_r + PTR_ONE;
      if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      rd_mem_r[wptr_r]   <= ll_rd;
      data_mem_r[wptr_r] <= ll_data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pend_r;
  logic [31:0] pend_nxt_s;

  // Clear on pop first so a same-cycle issue to the same register wins.
  always_comb begin
    pend_nxt_s = pend_r;
    if (pop_s && (head_rd_s != 5'd0)) begin
      pend_nxt_s[head_rd_s] = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      pend_nxt_s[iss_rd] = 1'b1;
    end else begin
      pend_nxt_s[0] = 1'b0;
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Pending-destination register.
  always_ff @(posedge clk) begin
    if (reset) pend_r <= 32'd0;
    else       pend_r <= pend_nxt_s;
  end

  assign pend_mask = pend_r;
`else
  logic unused_iss_s;
  assign unused_iss_s = &{1'b0, iss_valid, iss_rd};
  assign pend_mask    = 32'd0;
`endif

endmodule
